// File: rtl/sap1_pkg.sv
// ---------------------------------------------------------------------------
// sap1_pkg
//   Shared constants for the SAP-1 derived accumulator blocks.
//   - SAP1_WIDTH : default data width of accumulator, bus and stack entries.
//   - OP_*       : 3-bit operation codes presented on the accumulator's op port.
// ---------------------------------------------------------------------------
package sap1_pkg;

    localparam int SAP1_WIDTH = 8;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_PUSH = 3'd6;
    localparam logic [2:0] OP_POP  = 3'd7;

endpackage

// File: rtl/lifo_store.sv
// ---------------------------------------------------------------------------
// lifo_store
//   DEPTH-entry last-in/first-out store of WIDTH-bit words.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//     push, pop  : requests (never both at once); a push while full or a pop
//                  while empty is ignored and flagged on reject
//     wr_data    : word written on an accepted push
//     rd_data    : registered copy of the current top entry (0 when empty)
//     full/empty : occupancy flags, combinational from the stack pointer
//     reject     : combinational, 1 when the current request is refused
// ---------------------------------------------------------------------------
module lifo_store #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             reject
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic [WIDTH-1:0] top_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp_q == SPW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign reject  = (push & full) | (pop & empty);
    assign rd_data = top_q;

    // top_q mirrors mem[sp-1] so the popped word is available straight from
    // a register on the pop edge; after a pop it is refilled from the entry
    // below, which is still intact in mem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            top_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[AW'(sp_q)] <= wr_data;
            sp_q           <= sp_q + SPW'(1);
            top_q          <= wr_data;
        end else if (do_pop) begin
            sp_q  <= sp_q - SPW'(1);
            top_q <= (sp_q > SPW'(1)) ? mem[AW'(sp_q - SPW'(2))] : '0;
        end
    end

endmodule

// File: rtl/acc_stack_unit.sv
// ---------------------------------------------------------------------------
// acc_stack_unit
//   SAP-1 style accumulator with load/inc/dec/shift, a carry flag and a
//   DEPTH-entry save stack.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     Ea         : drive acc onto the shared bus
//     op         : operation code (see sap1_pkg OP_*), one per cycle
//     busIn      : bus data captured by LOAD
//     busOut     : acc when Ea=1, high-impedance otherwise
//     Avalue     : accumulator value, always driven
//     carry      : registered carry / borrow / shift-out flag
//     zero       : acc == 0
//     full/empty : save stack occupancy
//     err        : one-cycle pulse after a refused PUSH or POP
// ---------------------------------------------------------------------------
module acc_stack_unit
    import sap1_pkg::*;
#(
    parameter int WIDTH = SAP1_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Ea,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] busIn,
    output logic [WIDTH-1:0] busOut,
    output logic [WIDTH-1:0] Avalue,
    output logic             carry,
    output logic             zero,
    output logic             full,
    output logic             empty,
    output logic             err
);

    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             err_q;
    logic [WIDTH-1:0] stk_top;
    logic             stk_reject;

    // Returns {carry, acc} after one operation. The extra MSB of the
    // (WIDTH+1)-bit add/subtract is exactly the carry-out or borrow.
    function automatic logic [WIDTH:0] acc_next(
        input logic [2:0]       code,
        input logic [WIDTH-1:0] a,
        input logic             c,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] top,
        input logic             pop_ok
    );
        logic [WIDTH:0] r;
        r = {c, a};
        case (code)
            OP_LOAD: r = {1'b0, d};
            OP_INC:  r = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
            OP_DEC:  r = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
            OP_SHL:  r = {a, 1'b0};
            OP_SHR:  r = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_POP:  r = pop_ok ? {c, top} : {c, a};
            default: r = {c, a};
        endcase
        return r;
    endfunction

    lifo_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (op == OP_PUSH),
        .pop     (op == OP_POP),
        .wr_data (acc_q),
        .rd_data (stk_top),
        .full    (full),
        .empty   (empty),
        .reject  (stk_reject)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            {carry_q, acc_q} <= acc_next(op, acc_q, carry_q, busIn, stk_top, ~empty);
            err_q            <= stk_reject;
        end
    end

    assign busOut = Ea ? acc_q : {WIDTH{1'bz}};
    assign Avalue = acc_q;
    assign carry  = carry_q;
    assign zero   = (acc_q == '0);
    assign err    = err_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
module tb_acc_stack_unit;
    import sap1_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ea_a, ea_b;
    logic [2:0] op_a, op_b;
    logic [7:0] bus_a;
    logic [3:0] bus_b;
    wire  [7:0] busout_a;
    wire  [3:0] busout_b;
    logic [7:0] aval_a;
    logic [3:0] aval_b;
    logic       carry_a, zero_a, full_a, empty_a, err_a;
    logic       carry_b, zero_b, full_b, empty_b, err_b;

    acc_stack_unit #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .Ea(ea_a), .op(op_a), .busIn(bus_a),
        .busOut(busout_a), .Avalue(aval_a), .carry(carry_a), .zero(zero_a),
        .full(full_a), .empty(empty_a), .err(err_a)
    );

    acc_stack_unit #(.WIDTH(4), .DEPTH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .Ea(ea_b), .op(op_b), .busIn(bus_b),
        .busOut(busout_b), .Avalue(aval_b), .carry(carry_b), .zero(zero_b),
        .full(full_b), .empty(empty_b), .err(err_b)
    );

    typedef struct {
        int acc;
        int c;
        int err;
        int full;
        int empty;
    } exp_t;

    exp_t sbq_a[$];
    exp_t sbq_b[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: accumulator as an integer, stack as a queue.
    int m_acc[2];
    int m_c[2];
    int st_a[$];
    int st_b[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void reset_model();
        m_acc[0] = 0; m_acc[1] = 0;
        m_c[0]   = 0; m_c[1]   = 0;
        st_a.delete();
        st_b.delete();
    endfunction

    function automatic void model_step(input int i, input int op, input int bus, output exp_t e);
        int w, d, mask, acc, c, n, err;
        w    = (i == 0) ? 8 : 4;
        d    = (i == 0) ? 4 : 1;
        mask = (1 << w) - 1;
        acc  = m_acc[i];
        c    = m_c[i];
        err  = 0;
        n    = (i == 0) ? st_a.size() : st_b.size();
        case (op)
            1: begin acc = bus & mask; c = 0; end
            2: begin c = (acc == mask) ? 1 : 0; acc = (acc + 1) & mask; end
            3: begin c = (acc == 0) ? 1 : 0; acc = (acc - 1) & mask; end
            4: begin c = (acc >> (w - 1)) & 1; acc = (acc << 1) & mask; end
            5: begin c = acc & 1; acc = acc >> 1; end
            6: begin
                if (n < d) begin
                    if (i == 0) st_a.push_back(acc);
                    else        st_b.push_back(acc);
                    n++;
                end else err = 1;
            end
            7: begin
                if (n > 0) begin
                    if (i == 0) acc = st_a.pop_back();
                    else        acc = st_b.pop_back();
                    n--;
                end else err = 1;
            end
            default: ;
        endcase
        m_acc[i] = acc;
        m_c[i]   = c;
        e.acc    = acc;
        e.c      = c;
        e.err    = err;
        e.full   = (n == d) ? 1 : 0;
        e.empty  = (n == 0) ? 1 : 0;
    endfunction

    task automatic drive(input int oa, input int ba, input int ob, input int bb, input logic ea);
        @(negedge clk);
        op_a  = oa[2:0];
        bus_a = ba[7:0];
        op_b  = ob[2:0];
        bus_b = bb[3:0];
        ea_a  = ea;
        ea_b  = ea;
    endtask

    task automatic commit();
        exp_t ea, eb;
        @(posedge clk);
        model_step(0, int'(op_a), int'(bus_a), ea);
        model_step(1, int'(op_b), int'(bus_b), eb);
        sbq_a.push_back(ea);
        sbq_b.push_back(eb);
    endtask

    task automatic issue(input int oa, input int ba, input int ob, input int bb, input logic ea);
        drive(oa, ba, ob, bb, ea);
        commit();
    endtask

    task automatic ia(input int op, input int bus);
        issue(op, bus, 0, 0, 1'b0);
        #1;
    endtask

    task automatic ib(input int op, input int bus);
        issue(0, 0, op, bus, 1'b0);
        #1;
    endtask

    // Monitor: every cycle that had an op issued presents a result one edge later.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq_a.size() > 0) begin
            e = sbq_a.pop_front();
            check("A_acc",   int'(aval_a),  e.acc);
            check("A_carry", int'(carry_a), e.c);
            check("A_zero",  int'(zero_a),  (e.acc == 0) ? 1 : 0);
            check("A_full",  int'(full_a),  e.full);
            check("A_empty", int'(empty_a), e.empty);
            check("A_err",   int'(err_a),   e.err);
        end
        if (sbq_b.size() > 0) begin
            e = sbq_b.pop_front();
            check("B_acc",   int'(aval_b),  e.acc);
            check("B_carry", int'(carry_b), e.c);
            check("B_zero",  int'(zero_b),  (e.acc == 0) ? 1 : 0);
            check("B_full",  int'(full_b),  e.full);
            check("B_empty", int'(empty_b), e.empty);
            check("B_err",   int'(err_b),   e.err);
        end
    end

    initial begin
        int vals[4];
        vals[0] = 'h11; vals[1] = 'h22; vals[2] = 'h33; vals[3] = 'h44;
        rst_n = 1'b0;
        ea_a = 1'b0; ea_b = 1'b0;
        op_a = 3'd0; op_b = 3'd0;
        bus_a = 8'h00; bus_b = 4'h0;
        reset_model();

        // Reset state
        #3;
        check("rst_acc",   int'(aval_a),  0);
        check("rst_carry", int'(carry_a), 0);
        check("rst_zero",  int'(zero_a),  1);
        check("rst_empty", int'(empty_a), 1);
        check("rst_full",  int'(full_a),  0);
        check("rst_err",   int'(err_a),   0);
        check("rst_b_acc", int'(aval_b),  0);
        n_chk++;
        if (!(busout_a === 8'bzzzzzzzz)) begin
            n_fail++;
            $display("FAIL rst_bus_z: got %h, expected zz", busout_a);
        end
        n_chk++;
        if (!(busout_b === 4'bzzzz)) begin
            n_fail++;
            $display("FAIL rst_bus_b_z: got %h, expected z", busout_b);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD / INC / DEC wrap
        ia(OP_LOAD, 'hFF);
        ia(OP_INC, 0);
        check("wrap_inc_acc", int'(aval_a), 'h00);
        check("wrap_inc_c",   int'(carry_a), 1);
        check("wrap_inc_z",   int'(zero_a), 1);
        ia(OP_DEC, 0);
        check("wrap_dec_acc", int'(aval_a), 'hFF);
        check("wrap_dec_c",   int'(carry_a), 1);
        ia(OP_DEC, 0);
        check("dec2_acc", int'(aval_a), 'hFE);
        check("dec2_c",   int'(carry_a), 0);

        // Shifts
        ia(OP_LOAD, 'h81);
        ia(OP_SHL, 0);
        check("shl_acc", int'(aval_a), 'h02);
        check("shl_c",   int'(carry_a), 1);
        ia(OP_LOAD, 'h81);
        ia(OP_SHR, 0);
        check("shr_acc", int'(aval_a), 'h40);
        check("shr_c",   int'(carry_a), 1);
        ia(OP_SHR, 0);
        check("shr2_acc", int'(aval_a), 'h20);
        check("shr2_c",   int'(carry_a), 0);

        // Stack fill, overflow, drain, underflow
        for (int k = 0; k < 4; k++) begin
            ia(OP_LOAD, vals[k]);
            ia(OP_PUSH, 0);
        end
        check("stk_full", int'(full_a), 1);
        ia(OP_PUSH, 0);
        check("push_ovf_err", int'(err_a), 1);
        check("push_ovf_full", int'(full_a), 1);
        ia(OP_HOLD, 0);
        check("err_clear", int'(err_a), 0);
        for (int k = 0; k < 4; k++) begin
            ia(OP_POP, 0);
            check("pop_acc", int'(aval_a), vals[3-k]);
        end
        check("stk_empty", int'(empty_a), 1);
        ia(OP_POP, 0);
        check("pop_udf_err", int'(err_a), 1);
        check("pop_udf_acc", int'(aval_a), 'h11);
        ia(OP_POP, 0);
        check("err_b2b", int'(err_a), 1);
        ia(OP_HOLD, 0);

        // Bus tri-state and LOAD-through-bus timing
        ia(OP_LOAD, 'h3C);
        n_chk++;
        if (!(busout_a === 8'bzzzzzzzz)) begin
            n_fail++;
            $display("FAIL bus_z: got %h, expected zz", busout_a);
        end
        drive(OP_LOAD, 'hC3, 0, 0, 1'b1);
        #1;
        check("bus_pre", int'(busout_a), 'h3C);
        commit();
        #1;
        check("bus_post", int'(busout_a), 'hC3);

        // Asynchronous reset mid-stream (acc=0x5A, carry=1, sp=2)
        ia(OP_LOAD, 'h11); ia(OP_PUSH, 0);
        ia(OP_LOAD, 'h22); ia(OP_PUSH, 0);
        ia(OP_LOAD, 'hAD); ia(OP_SHL, 0);
        check("pre_rst_acc", int'(aval_a), 'h5A);
        @(negedge clk);
        op_a = OP_HOLD; op_b = OP_HOLD; ea_a = 1'b0; ea_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_acc",   int'(aval_a),  0);
        check("arst_carry", int'(carry_a), 0);
        check("arst_empty", int'(empty_a), 1);
        check("arst_err",   int'(err_a),   0);
        reset_model();
        #1 rst_n = 1'b1;

        // WIDTH=4, DEPTH=1 instance
        ib(OP_LOAD, 'hF);
        ib(OP_INC, 0);
        check("b_inc_acc", int'(aval_b), 0);
        check("b_inc_c",   int'(carry_b), 1);
        ib(OP_LOAD, 'h9);
        ib(OP_PUSH, 0);
        check("b_full", int'(full_b), 1);
        ib(OP_PUSH, 0);
        check("b_push_err", int'(err_b), 1);
        ib(OP_LOAD, 'h3);
        ib(OP_POP, 0);
        check("b_pop_acc", int'(aval_b), 'h9);
        ib(OP_POP, 0);
        check("b_pop_err", int'(err_b), 1);
        check("b_pop_hold", int'(aval_b), 'h9);

        // Randomized traffic on both instances
        for (int k = 0; k < 400; k++) begin
            issue($urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 7), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        check("sbq_drained", sbq_a.size() + sbq_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
